mod_n_updown_counter: RTL and testbench

- Parametrised modulo-N digit counter for the clock datapath. Replaces the fixed mod-10, gated-clock counter.
- Single clock domain. All events arrive as synchronous enables, never as clock gating.
- Counts up on a carry-in tick from the lower digit. In set mode, it is adjusted up or down by debounced buttons, with press-and-hold auto-repeat.
- Emits one-cycle carry/borrow pulses so digits cascade (sec-units → sec-tens → min…).

---
 rtl/clock_pkg.sv | 26 ++
 rtl/btn_autorepeat.sv | 102 ++++++++++
 rtl/mod_n_updown_counter.sv | 94 +++++++++
 tb/tb_mod_n_updown_counter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// ============================================================================
// Module : clock_pkg
// Brief  : Shared types and digit moduli for the clock datapath counters.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package clock_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } btn_state_e;

  localparam int SEC_UNITS = 10;
  localparam int SEC_TENS  = 6;
  localparam int HOUR_24   = 24;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/btn_autorepeat.sv
// ============================================================================
// Module : btn_autorepeat
// Brief  : Press/hold auto-repeat FSM producing one-cycle inc/dec step pulses.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_autorepeat
  import clock_pkg::*;
#(
  parameter int REPEAT_DELAY  = 4,
  parameter int REPEAT_PERIOD = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic inc_btn,
  input  logic dec_btn,
  output logic inc_step,
  output logic dec_step
);

  localparam int TW = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);
  localparam logic [TW-1:0] c_delay  = TW'(REPEAT_DELAY);
  localparam logic [TW-1:0] c_period = TW'(REPEAT_PERIOD);

  btn_state_e      r_state, w_state_nxt;
  logic [TW-1:0]   r_tmr, w_tmr_nxt, w_tmr_inc;
  logic            r_dir_up, w_dir_nxt;
  logic            r_inc_rel, r_dec_rel;
  logic            w_req_inc, w_req_dec, w_same;

  assign w_req_inc = inc_btn & ~dec_btn;
  assign w_req_dec = dec_btn & ~inc_btn;
  assign w_same    = r_dir_up ? w_req_inc : w_req_dec;
  assign w_tmr_inc = r_tmr + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_tmr_nxt   = r_tmr;
    w_dir_nxt   = r_dir_up;
    inc_step    = 1'b0;
    dec_step    = 1'b0;
    if (!enable) begin
      w_state_nxt = IDLE;
      w_tmr_nxt   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_tmr_nxt = '0;
          if (w_req_inc && r_inc_rel) begin
            inc_step    = 1'b1;
            w_dir_nxt   = 1'b1;
            w_state_nxt = DELAY;
          end else if (w_req_dec && r_dec_rel) begin
            dec_step    = 1'b1;
            w_dir_nxt   = 1'b0;
            w_state_nxt = DELAY;
          end
        end
        DELAY, REPEAT: begin
          if (!w_same) begin
            w_state_nxt = IDLE;
            w_tmr_nxt   = '0;
          end else if (w_tmr_inc == ((r_state == DELAY) ? c_delay : c_period)) begin
            inc_step    = r_dir_up;
            dec_step    = ~r_dir_up;
            w_tmr_nxt   = '0;
            w_state_nxt = REPEAT;
          end else begin
            w_tmr_nxt = w_tmr_inc;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_tmr_nxt   = '0;
        end
      endcase
    end
  end

  // History bits mean "button seen released"; clearing them on reset makes a
  // button held through reset wait for a genuine 0->1 before stepping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_tmr     <= '0;
      r_dir_up  <= 1'b0;
      r_inc_rel <= 1'b0;
      r_dec_rel <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_tmr     <= w_tmr_nxt;
      r_dir_up  <= w_dir_nxt;
      r_inc_rel <= ~inc_btn;
      r_dec_rel <= ~dec_btn;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mod_n_updown_counter.sv
// ============================================================================
// Module : mod_n_updown_counter
// Brief  : Modulo-N clock digit with tick count-up, load and button set mode.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mod_n_updown_counter
  import clock_pkg::*;
#(
  parameter int MODULUS       = SEC_UNITS,
  parameter int WIDTH         = 4,
  parameter int REPEAT_DELAY  = 4,
  parameter int REPEAT_PERIOD = 2,
  parameter int SET_PROPAGATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             set_mode,
  input  logic             inc_btn,
  input  logic             dec_btn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             carry,
  output logic             borrow
);

  localparam logic [WIDTH-1:0] c_max  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   c_mod  = (WIDTH + 1)'(MODULUS);
  localparam logic             c_prop = (SET_PROPAGATE != 0);

  logic [WIDTH-1:0] r_count, w_count_nxt, w_up, w_dn;
  logic             r_carry, r_borrow, w_carry_nxt, w_borrow_nxt;
  logic             w_at_max, w_at_zero, w_inc_step, w_dec_step;

  btn_autorepeat #(
    .REPEAT_DELAY  (REPEAT_DELAY),
    .REPEAT_PERIOD (REPEAT_PERIOD)
  ) u_btn (
    .clk      (clk),
    .rst      (rst),
    .enable   (set_mode & ~load),
    .inc_btn  (inc_btn),
    .dec_btn  (dec_btn),
    .inc_step (w_inc_step),
    .dec_step (w_dec_step)
  );

  assign w_at_max  = (r_count == c_max);
  assign w_at_zero = (r_count == '0);
  assign w_up      = w_at_max  ? '0    : r_count + 1'b1;
  assign w_dn      = w_at_zero ? c_max : r_count - 1'b1;

  always_comb begin
    w_count_nxt  = r_count;
    w_carry_nxt  = 1'b0;
    w_borrow_nxt = 1'b0;
    if (load) begin
      w_count_nxt = ({1'b0, load_value} < c_mod) ? load_value : '0;
    end else if (set_mode) begin
      if (w_inc_step) begin
        w_count_nxt = w_up;
        w_carry_nxt = w_at_max & c_prop;
      end else if (w_dec_step) begin
        w_count_nxt  = w_dn;
        w_borrow_nxt = w_at_zero & c_prop;
      end
    end else if (tick) begin
      w_count_nxt = w_up;
      w_carry_nxt = w_at_max;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count  <= '0;
      r_carry  <= 1'b0;
      r_borrow <= 1'b0;
    end else begin
      r_count  <= w_count_nxt;
      r_carry  <= w_carry_nxt;
      r_borrow <= w_borrow_nxt;
    end
  end

  assign count  = r_count;
  assign carry  = r_carry;
  assign borrow = r_borrow;

endmodule

`default_nettype wire

// File: tb/tb_mod_n_updown_counter.sv
// ============================================================================
// Module : tb_mod_n_updown_counter
// Brief  : Scoreboard bench for two counter configurations sharing one stimulus.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mod_n_updown_counter;

  logic       clk = 1'b0;
  logic       rst, tick, set_mode, inc_btn, dec_btn, load;
  logic [3:0] load_value;
  logic [3:0] count_a;
  logic [2:0] count_b;
  logic       carry_a, borrow_a, carry_b, borrow_b;

  always #5 clk = ~clk;

  mod_n_updown_counter #(
    .MODULUS(10), .WIDTH(4), .REPEAT_DELAY(4), .REPEAT_PERIOD(2), .SET_PROPAGATE(0)
  ) dut_a (
    .clk(clk), .rst(rst), .tick(tick), .set_mode(set_mode),
    .inc_btn(inc_btn), .dec_btn(dec_btn), .load(load), .load_value(load_value),
    .count(count_a), .carry(carry_a), .borrow(borrow_a)
  );

  mod_n_updown_counter #(
    .MODULUS(6), .WIDTH(3), .REPEAT_DELAY(3), .REPEAT_PERIOD(1), .SET_PROPAGATE(1)
  ) dut_b (
    .clk(clk), .rst(rst), .tick(tick), .set_mode(set_mode),
    .inc_btn(inc_btn), .dec_btn(dec_btn), .load(load), .load_value(load_value[2:0]),
    .count(count_b), .carry(carry_b), .borrow(borrow_b)
  );

  typedef struct { int cnt; int cy; int bw; } exp_t;
  exp_t q_exp[2][$];

  int checks = 0;
  int errors = 0;

  // Reference model: hold length in cycles since the fresh press (-1 = none)
  int m_cnt[2], m_hold[2], m_dir[2];
  bit m_inc_low, m_dec_low;
  int c_mod[2] = '{10, 6};
  int c_dly[2] = '{4, 3};
  int c_per[2] = '{2, 1};
  int c_prp[2] = '{0, 1};
  int c_lvm[2] = '{16, 8};

  task automatic model_cycle();
    int dir;
    dir = (inc_btn && !dec_btn) ? 1 : ((dec_btn && !inc_btn) ? -1 : 0);
    for (int k = 0; k < 2; k++) begin
      exp_t e;
      int   step, lv;
      e.cy = 0; e.bw = 0; step = 0;
      lv = int'(load_value) % c_lvm[k];
      if (rst) begin
        m_cnt[k] = 0; m_hold[k] = -1;
      end else if (load) begin
        m_cnt[k] = (lv < c_mod[k]) ? lv : 0; m_hold[k] = -1;
      end else if (set_mode) begin
        if (m_hold[k] >= 0) begin
          if (dir == m_dir[k]) begin
            m_hold[k]++;
            if (m_hold[k] == c_dly[k] ||
                (m_hold[k] > c_dly[k] && (m_hold[k] - c_dly[k]) % c_per[k] == 0))
              step = dir;
          end else begin
            m_hold[k] = -1;
          end
        end else if ((dir == 1 && m_inc_low) || (dir == -1 && m_dec_low)) begin
          m_hold[k] = 0; m_dir[k] = dir; step = dir;
        end
        if (step == 1) begin
          if (m_cnt[k] == c_mod[k] - 1) begin m_cnt[k] = 0; e.cy = c_prp[k]; end
          else m_cnt[k]++;
        end else if (step == -1) begin
          if (m_cnt[k] == 0) begin m_cnt[k] = c_mod[k] - 1; e.bw = c_prp[k]; end
          else m_cnt[k]--;
        end
      end else begin
        m_hold[k] = -1;
        if (tick) begin
          if (m_cnt[k] == c_mod[k] - 1) begin m_cnt[k] = 0; e.cy = 1; end
          else m_cnt[k]++;
        end
      end
      e.cnt = m_cnt[k];
      q_exp[k].push_back(e);
    end
    m_inc_low = !rst && !inc_btn;
    m_dec_low = !rst && !dec_btn;
  endtask

  task automatic cyc(input bit r, input bit t, input bit s, input bit i,
                     input bit d, input bit l, input int lv);
    @(negedge clk);
    rst = r; tick = t; set_mode = s; inc_btn = i; dec_btn = d; load = l;
    load_value = 4'(lv);
    model_cycle();
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Monitor: outputs are registered, so one expected entry per clock edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q_exp[0].size() > 0) begin
        exp_t e;
        e = q_exp[0].pop_front();
        chk("count_a",  int'(count_a),  e.cnt);
        chk("carry_a",  int'(carry_a),  e.cy);
        chk("borrow_a", int'(borrow_a), e.bw);
      end
      if (q_exp[1].size() > 0) begin
        exp_t e;
        e = q_exp[1].pop_front();
        chk("count_b",  int'(count_b),  e.cnt);
        chk("carry_b",  int'(carry_b),  e.cy);
        chk("borrow_b", int'(borrow_b), e.bw);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: got no end of stimulus expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit ri, rd, rs;
    rst = 1'b1; tick = 1'b0; set_mode = 1'b0; inc_btn = 1'b0; dec_btn = 1'b0;
    load = 1'b0; load_value = '0;
    m_inc_low = 1'b0; m_dec_low = 1'b0;
    for (int k = 0; k < 2; k++) begin m_cnt[k] = 0; m_hold[k] = -1; m_dir[k] = 0; end

    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    // Ticks from reset, with an idle cycle between some of them
    for (int n = 0; n < 12; n++) begin
      cyc(0, 1, 0, 0, 0, 0, 0);
      if (n % 3 == 0) cyc(0, 0, 0, 0, 0, 0, 0);
    end
    // Single dec pulse from zero in set mode
    cyc(0, 0, 1, 0, 0, 1, 0);
    cyc(0, 0, 1, 0, 1, 0, 0);
    repeat (5) cyc(0, 0, 1, 0, 0, 0, 0);
    // Press-and-hold inc from 3 for 12 cycles, then release
    cyc(0, 0, 1, 0, 0, 1, 3);
    repeat (12) cyc(0, 0, 1, 1, 0, 0, 0);
    repeat (4) cyc(0, 0, 1, 0, 0, 0, 0);
    // Both buttons, then inc changed into dec while held
    repeat (3) cyc(0, 0, 1, 1, 1, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    repeat (2) cyc(0, 0, 1, 1, 0, 0, 0);
    repeat (6) cyc(0, 0, 1, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    // Load beats a simultaneous tick; out-of-range load clears
    cyc(0, 1, 0, 0, 0, 1, 7);
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 1, 12);
    cyc(0, 0, 0, 0, 0, 1, 5);
    // Reset during repeat with inc held, then a fresh press
    cyc(0, 0, 1, 0, 0, 1, 2);
    repeat (8) cyc(0, 0, 1, 1, 0, 0, 0);
    cyc(1, 0, 1, 1, 0, 0, 0);
    repeat (5) cyc(0, 0, 1, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    repeat (3) cyc(0, 0, 1, 1, 0, 0, 0);
    // set_mode drops mid-hold alongside a tick
    cyc(0, 1, 0, 1, 0, 0, 0);
    cyc(0, 0, 1, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);

    ri = 0; rd = 0; rs = 1;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 5) == 0) begin
        ri = ($urandom_range(0, 2) == 0);
        rd = ($urandom_range(0, 3) == 0);
      end
      if ($urandom_range(0, 39) == 0) rs = !rs;
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 2) == 0, rs, ri, rd,
          $urandom_range(0, 24) == 0, int'($urandom_range(0, 15)));
    end
    cyc(0, 0, 0, 0, 0, 0, 0);

    @(posedge clk);
    #2;
    for (int k = 0; k < 2; k++) chk("queue_drain", q_exp[k].size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
